ps2_key_event_queue: RTL and testbench

//  Consumes the PS/2 scancode byte stream and tracks make/break/extended prefixes.

---
 rtl/ps2_key_event_queue.sv | 186 ++++++++++++++++++
 tb/tb_ps2_key_event_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_queue.sv
// PS/2 scancode decoder with typematic-repeat suppression and a show-ahead
// key-event FIFO feeding the game-control FSM.
module ps2_key_event_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned CODE_W        = 5,
  parameter int unsigned REPEAT_FILTER = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [7:0]                 in_byte,
  input  logic                       in_valid,
  output logic [CODE_W-1:0]          out_letter,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [7:0] BYTE_BRK = 8'hF0;
  localparam logic [7:0] BYTE_EXT = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t state, state_next;

  logic [7:0]       held;
  logic             held_vld;
  logic             push;
  logic             hold_set;
  logic             hold_clr;
  logic             hit;
  logic [IDX_W-1:0] idx;

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CNT_W-1:0] count_next;
  logic [IDX_W-1:0] head_next;
  logic             full;
  logic             pop;
  logic             accept;

  // Scancode to key index: A..Z -> 0..25, Enter -> 26; MSB flags a hit.
  function automatic logic [IDX_W:0] map_code(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, 5'd0};
      8'h32: return {1'b1, 5'd1};
      8'h21: return {1'b1, 5'd2};
      8'h23: return {1'b1, 5'd3};
      8'h24: return {1'b1, 5'd4};
      8'h2B: return {1'b1, 5'd5};
      8'h34: return {1'b1, 5'd6};
      8'h33: return {1'b1, 5'd7};
      8'h43: return {1'b1, 5'd8};
      8'h3B: return {1'b1, 5'd9};
      8'h42: return {1'b1, 5'd10};
      8'h4B: return {1'b1, 5'd11};
      8'h3A: return {1'b1, 5'd12};
      8'h31: return {1'b1, 5'd13};
      8'h44: return {1'b1, 5'd14};
      8'h4D: return {1'b1, 5'd15};
      8'h15: return {1'b1, 5'd16};
      8'h2D: return {1'b1, 5'd17};
      8'h1B: return {1'b1, 5'd18};
      8'h2C: return {1'b1, 5'd19};
      8'h3C: return {1'b1, 5'd20};
      8'h2A: return {1'b1, 5'd21};
      8'h1D: return {1'b1, 5'd22};
      8'h22: return {1'b1, 5'd23};
      8'h35: return {1'b1, 5'd24};
      8'h1A: return {1'b1, 5'd25};
      8'h5A: return {1'b1, 5'd26};
      default: return '0;
    endcase
  endfunction

  assign {hit, idx} = map_code(in_byte);

  // Prefix-tracking state register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next state: advance only on a received byte.
  always_comb begin
    state_next = state;
    if (in_valid) begin
      case (state)
        S_IDLE: begin
          if (in_byte == BYTE_BRK)      state_next = S_BRK;
          else if (in_byte == BYTE_EXT) state_next = S_EXT;
        end
        S_EXT:   state_next = (in_byte == BYTE_BRK) ? S_EXT_BRK : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Decode actions: queue a fresh make, track the held key, release on break.
  always_comb begin
    push     = 1'b0;
    hold_set = 1'b0;
    hold_clr = 1'b0;
    if (in_valid) begin
      case (state)
        S_IDLE: begin
          if (hit && !((REPEAT_FILTER != 0) && held_vld && (held == in_byte))) begin
            push     = 1'b1;
            hold_set = 1'b1;
          end
        end
        S_BRK:   hold_clr = held_vld && (held == in_byte);
        default: ;
      endcase
    end
  end

  // Held-key register for repeat suppression.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      held     <= '0;
      held_vld <= 1'b0;
    end else if (hold_set) begin
      held     <= in_byte;
      held_vld <= 1'b1;
    end else if (hold_clr) begin
      held_vld <= 1'b0;
    end
  end

  assign full   = (fifo_count == CNT_W'(DEPTH));
  assign pop    = out_valid && out_ready;
  assign accept = push && (!full || pop);

  // FIFO bookkeeping and the head value visible after this edge.
  always_comb begin
    rd_next    = pop    ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_next    = accept ? wr_ptr + PTR_W'(1) : wr_ptr;
    count_next = fifo_count;
    case ({accept, pop})
      2'b10:   count_next = fifo_count + CNT_W'(1);
      2'b01:   count_next = fifo_count - CNT_W'(1);
      default: count_next = fifo_count;
    endcase
    head_next = '0;
    if (count_next != '0) begin
      // When nothing older survives this edge, the head is the byte being pushed.
      if ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)) head_next = idx;
      else                                                          head_next = mem[rd_next];
    end
  end

  // Entry storage; contents are don't-care while not counted.
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= idx;
  end

  // Pointers, count and registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      out_letter <= '0;
      overflow   <= 1'b0;
    end else begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      fifo_count <= count_next;
      out_valid  <= (count_next != '0);
      out_letter <= CODE_W'(head_next);
      overflow   <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench for ps2_key_event_queue: expected key indices are queued
// as bytes are driven and compared as the FIFO head is popped.
module tb_ps2_key_event_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);

  logic              clock;
  logic              resetn;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_letter;
  logic              out_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic [CODE_W-1:0] nf_letter;
  logic              nf_valid;
  logic [CNT_W-1:0]  nf_count;
  logic              nf_overflow;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned sb [$];

  // Reference key order: index i is the scancode of letter i, then Enter.
  logic [7:0] key_codes [27] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h5A
  };

  ps2_key_event_queue #(.DEPTH(DEPTH), .CODE_W(CODE_W), .REPEAT_FILTER(1)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .out_letter (out_letter),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  ps2_key_event_queue #(.DEPTH(DEPTH), .CODE_W(CODE_W), .REPEAT_FILTER(0)) dut_nf (
    .clock      (clock),
    .resetn     (resetn),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .out_letter (nf_letter),
    .out_valid  (nf_valid),
    .out_ready  (out_ready),
    .fifo_count (nf_count),
    .overflow   (nf_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int unsigned key_index(input logic [7:0] code);
    for (int i = 0; i < 27; i++) if (key_codes[i] == code) return i;
    return 99;
  endfunction

  // Drive one byte; queue its key index when a push is expected.
  task automatic send(input logic [7:0] b, input bit expect_push);
    in_byte  = b;
    in_valid = 1'b1;
    if (expect_push) sb.push_back(key_index(b));
    tick();
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  // Pop the head and compare it against the scoreboard.
  task automatic pop_check(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    else                chk({tag, "_letter"}, 32'(out_letter), sb.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"},    32'(out_valid),  32'd0);
    chk({tag, "_count"},    32'(fifo_count), 32'd0);
    chk({tag, "_letter"},   32'(out_letter), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow),   32'd0);
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    resetn = 1'b1;
    sb.delete();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    resetn = 1'b1;

    // Single make, then drain.
    send(8'h1C, 1'b1);
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_letter", 32'(out_letter), 32'd0);
    pop_check("t1_pop");
    chk("t1_count_after", 32'(fifo_count), 32'd0);
    chk("t1_valid_after", 32'(out_valid), 32'd0);

    // Typematic repeats are filtered until a break.
    do_reset();
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    chk("t2_count", 32'(fifo_count), 32'd1);
    chk("t2_nf_count", 32'(nf_count), 32'd3);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b1);
    chk("t2_count2", 32'(fifo_count), 32'd2);
    pop_check("t2_pop_a");
    pop_check("t2_pop_b");

    // Extended keys and breaks never queue; FSM returns to IDLE.
    do_reset();
    send(8'hE0, 1'b0);
    send(8'h5A, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h32, 1'b0);
    send(8'h5A, 1'b1);
    chk("t3_count", 32'(fifo_count), 32'd1);
    pop_check("t3_pop");
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h1A, 1'b1);
    pop_check("t3_extbrk_pop");

    // Fill, overflow, then a full push with a same-cycle pop.
    do_reset();
    send(8'h1C, 1'b1);
    send(8'h32, 1'b1);
    send(8'h21, 1'b1);
    send(8'h23, 1'b1);
    send(8'h24, 1'b0);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_count_full", 32'(fifo_count), 32'd4);
    tick();
    chk("t4_overflow_pulse", 32'(overflow), 32'd0);
    send(8'hF0, 1'b0);
    send(8'h24, 1'b0);
    chk("t4_still_full", 32'(fifo_count), 32'd4);
    chk("t4_head0", 32'(out_letter), sb.pop_front());
    in_byte   = 8'h24;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sb.push_back(key_index(8'h24));
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t4_no_overflow", 32'(overflow), 32'd0);
    chk("t4_count_kept", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) pop_check($sformatf("t4_drain%0d", i));
    chk("t4_empty", 32'(out_valid), 32'd0);

    // Reset clears a pending break prefix and queued data, overriding input.
    do_reset();
    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0);
    resetn   = 1'b0;
    in_byte  = 8'h1A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb.delete();
    check_idle_outputs("t5_in_reset");
    resetn = 1'b1;
    send(8'h32, 1'b1);
    pop_check("t5_pop");

    // Unmapped bytes are ignored.
    do_reset();
    send(8'h16, 1'b0);
    send(8'h45, 1'b0);
    send(8'hE1, 1'b0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    send(8'h1A, 1'b1);
    pop_check("t6_pop");

    // Push and pop together at mid occupancy keeps count and order.
    do_reset();
    send(8'h32, 1'b1);
    chk("t7_head", 32'(out_letter), sb.pop_front());
    in_byte   = 8'h21;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sb.push_back(key_index(8'h21));
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t7_count", 32'(fifo_count), 32'd1);
    send(8'h5A, 1'b1);
    pop_check("t7_pop_a");
    pop_check("t7_pop_b");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t7_empty_ready", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
